// File: rtl/icap_pkg.sv
// Shared constants, FSM state type and bit-reversal helper for the ICAP reboot master.
package icap_pkg;

  localparam logic [15:0] ICAP_DUMMY      = 16'hFFFF;
  localparam logic [15:0] ICAP_SYNC       = 16'hAA99;
  localparam logic [15:0] ICAP_WR_GEN1    = 16'h3261;
  localparam logic [15:0] ICAP_WR_GEN2    = 16'h3281;
  localparam logic [15:0] ICAP_WR_CMD     = 16'h30A1;
  localparam logic [15:0] ICAP_CMD_REBOOT = 16'h000E;
  localparam logic [15:0] ICAP_NOOP       = 16'h2000;

  localparam int ICAP_SEQ_WORDS = 12;
  localparam int ICAP_SEQ_BYTES = 2 * ICAP_SEQ_WORDS;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_GAP   = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/icap_reboot_master_if.sv
// Wishbone link between the reboot master and the 8-bit ICAP responder.
interface icap_reboot_master_if;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [31:0] dat_o;
  logic        ack_i;

  modport master (output cyc_o, stb_o, we_o, dat_o, input ack_i);
  modport slave  (input cyc_o, stb_o, we_o, dat_o, output ack_i);
endinterface

// File: rtl/icap_reboot_rom.sv
// Word table of the Spartan-3A IPROG multiboot sequence, built around the latched flash address.
module icap_reboot_rom
  import icap_pkg::*;
(
  input  logic [3:0]  word_idx,
  input  logic [23:0] addr,
  input  logic [7:0]  spi_opcode,
  output logic [15:0] word
);

  always_comb begin
    word = ICAP_NOOP;
    case (word_idx)
      4'd0:    word = ICAP_DUMMY;
      4'd1:    word = ICAP_SYNC;
      4'd2:    word = ICAP_WR_GEN1;
      4'd3:    word = addr[15:0];
      4'd4:    word = ICAP_WR_GEN2;
      4'd5:    word = {spi_opcode, addr[23:16]};
      4'd6:    word = ICAP_WR_CMD;
      4'd7:    word = ICAP_CMD_REBOOT;
      default: word = ICAP_NOOP;
    endcase
  end

endmodule

// File: rtl/icap_reboot_master.sv
// Wishbone initiator that streams the IPROG reboot sequence to the ICAP responder, one byte per write.
module icap_reboot_master
  import icap_pkg::*;
#(
  parameter logic [7:0] SPI_OPCODE = 8'h0B,
  parameter bit         BIT_SWAP   = 1'b1,
  parameter int         TIMEOUT    = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [23:0]                 boot_addr,
  icap_reboot_master_if.master        bus,
  output logic                        busy,
  output logic                        done,
  output logic                        err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [4:0] LAST_IDX    = 5'(ICAP_SEQ_BYTES - 1);

  state_t      state_reg, state_next;
  logic [4:0]  idx_reg, idx_next;
  logic [7:0]  cnt_reg, cnt_next;
  logic [23:0] addr_reg, addr_next;
  logic [15:0] rom_word;
  logic [7:0]  cur_byte;
  logic [7:0]  bus_byte;

  icap_reboot_rom u_rom (
    .word_idx   (idx_reg[4:1]),
    .addr       (addr_reg),
    .spi_opcode (SPI_OPCODE),
    .word       (rom_word)
  );

  // Even byte index carries the high byte of the word.
  assign cur_byte = idx_reg[0] ? rom_word[7:0] : rom_word[15:8];
  assign bus_byte = BIT_SWAP ? bit_rev8(cur_byte) : cur_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      cnt_reg   <= '0;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      addr_reg  <= addr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    addr_next  = addr_reg;
    bus.cyc_o  = 1'b0;
    bus.stb_o  = 1'b0;
    bus.we_o   = 1'b0;
    bus.dat_o  = '0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;

    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR: begin
        done = (state_reg == ST_DONE);
        err  = (state_reg == ST_ERR);
        if (start) begin
          addr_next  = boot_addr;
          idx_next   = '0;
          cnt_next   = '0;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        bus.cyc_o = 1'b1;
        bus.stb_o = 1'b1;
        bus.we_o  = 1'b1;
        bus.dat_o = {24'd0, bus_byte};
        busy      = 1'b1;
        // An ack on the final allowed cycle still counts as success.
        if (bus.ack_i) begin
          state_next = ST_GAP;
        end else begin
          cnt_next = cnt_reg + 8'd1;
          if (cnt_next == TIMEOUT_CNT) state_next = ST_ERR;
        end
      end
      ST_GAP: begin
        busy = 1'b1;
        if (idx_reg == LAST_IDX) begin
          state_next = ST_DONE;
        end else begin
          idx_next   = idx_reg + 5'd1;
          cnt_next   = '0;
          state_next = ST_ISSUE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_icap_reboot_master.sv
// Bench: two masters (plain / bit-swapped short-timeout) against modelled ICAP responders.
module tb_icap_reboot_master;

  localparam int NEVER = 100000;
  localparam int T1    = 10;
  localparam int PMAX  = 8192;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [23:0] boot_addr = '0;

  always #5 clk = ~clk;

  icap_reboot_master_if bus0();
  icap_reboot_master_if bus1();

  logic        busy [2];
  logic        done [2];
  logic        err  [2];
  logic        cyc  [2];
  logic        stb  [2];
  logic        we   [2];
  logic [31:0] dat  [2];
  logic        ack  [2];

  icap_reboot_master #(.SPI_OPCODE(8'h0B), .BIT_SWAP(1'b0), .TIMEOUT(255)) dut0 (
    .clk(clk), .reset(reset), .start(start), .boot_addr(boot_addr),
    .bus(bus0.master), .busy(busy[0]), .done(done[0]), .err(err[0]));

  icap_reboot_master #(.SPI_OPCODE(8'h0B), .BIT_SWAP(1'b1), .TIMEOUT(T1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .boot_addr(boot_addr),
    .bus(bus1.master), .busy(busy[1]), .done(done[1]), .err(err[1]));

  assign cyc[0] = bus0.cyc_o;  assign stb[0] = bus0.stb_o;
  assign we[0]  = bus0.we_o;   assign dat[0] = bus0.dat_o;
  assign cyc[1] = bus1.cyc_o;  assign stb[1] = bus1.stb_o;
  assign we[1]  = bus1.we_o;   assign dat[1] = bus1.dat_o;
  assign bus0.ack_i = ack[0];
  assign bus1.ack_i = ack[1];

  // Responder: ack after lat_tab cycles of waiting on transfer number xi_r.
  int lat_tab [2][24];

  for (genvar gi = 0; gi < 2; gi++) begin : g_resp
    int sc_r;
    int xi_r;
    assign ack[gi] = stb[gi] && (sc_r == lat_tab[gi][xi_r % 24]);
    always @(posedge clk) begin
      if (reset) begin
        sc_r <= 0;
        xi_r <= 0;
      end else begin
        if (start && !busy[gi]) xi_r <= 0;
        else if (stb[gi] && ack[gi]) xi_r <= xi_r + 1;
        sc_r <= (stb[gi] && !ack[gi]) ? sc_r + 1 : 0;
      end
    end
  end

  typedef struct packed {
    logic        cyc;
    logic [31:0] dat;
    logic        busy;
    logic        done;
    logic        err;
  } rec_t;

  rec_t        plan [2][PMAX];
  int          plen [2];
  int          pptr [2];
  rec_t        cur  [2];
  logic        fin_done [2];
  logic        fin_err  [2];
  logic [7:0]  cap  [2][24];
  int          ncap [2];
  int          checks = 0;
  int          failures = 0;

  logic [7:0] nom [24] = '{8'hFF, 8'hFF, 8'hAA, 8'h99, 8'h32, 8'h61, 8'h50, 8'h00,
                           8'h32, 8'h81, 8'h0B, 8'h0A, 8'h30, 8'hA1, 8'h00, 8'h0E,
                           8'h20, 8'h00, 8'h20, 8'h00, 8'h20, 8'h00, 8'h20, 8'h00};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic [23:0] a, input int i, input bit swap);
    logic [15:0] w [12];
    logic [7:0]  b;
    logic [7:0]  r;
    w = '{16'hFFFF, 16'hAA99, 16'h3261, a[15:0], 16'h3281, {8'h0B, a[23:16]},
          16'h30A1, 16'h000E, 16'h2000, 16'h2000, 16'h2000, 16'h2000};
    b = (i % 2 == 0) ? w[i/2][15:8] : w[i/2][7:0];
    r = b;
    if (swap) for (int k = 0; k < 8; k++) r[k] = b[7-k];
    return r;
  endfunction

  task automatic push(input int d, input rec_t r);
    if (plen[d] < PMAX) begin
      plan[d][plen[d]] = r;
      plen[d]++;
    end
  endtask

  // Whole transfer timeline: each byte holds the bus for lat+1 cycles (or the timeout), then one idle gap.
  task automatic build(input int d, input logic [23:0] a);
    int   tmo;
    int   n;
    rec_t r;
    tmo = (d == 0) ? 255 : T1;
    plen[d] = 0;
    pptr[d] = 0;
    fin_done[d] = 1'b0;
    fin_err[d]  = 1'b0;
    for (int i = 0; i < 24; i++) begin
      n = lat_tab[d][i] + 1;
      r = '{cyc: 1'b1, dat: {24'd0, exp_byte(a, i, d == 1)}, busy: 1'b1, done: 1'b0, err: 1'b0};
      if (n > tmo) begin
        for (int k = 0; k < tmo; k++) push(d, r);
        fin_err[d] = 1'b1;
        return;
      end
      for (int k = 0; k < n; k++) push(d, r);
      push(d, '{cyc: 1'b0, dat: 32'd0, busy: 1'b1, done: 1'b0, err: 1'b0});
    end
    fin_done[d] = 1'b1;
  endtask

  // Compare every cycle mid-period, then predict the next cycle from the inputs the next edge will see.
  initial begin
    for (int d = 0; d < 2; d++) begin
      cur[d] = '0; plen[d] = 0; pptr[d] = 0; ncap[d] = 0;
      fin_done[d] = 1'b0; fin_err[d] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("dut%0d_cyc", d),  32'(cyc[d]),  32'(cur[d].cyc));
        chk($sformatf("dut%0d_stb", d),  32'(stb[d]),  32'(cur[d].cyc));
        chk($sformatf("dut%0d_we", d),   32'(we[d]),   32'(cur[d].cyc));
        chk($sformatf("dut%0d_dat", d),  dat[d],       cur[d].dat);
        chk($sformatf("dut%0d_busy", d), 32'(busy[d]), 32'(cur[d].busy));
        chk($sformatf("dut%0d_done", d), 32'(done[d]), 32'(cur[d].done));
        chk($sformatf("dut%0d_err", d),  32'(err[d]),  32'(cur[d].err));
        if (stb[d] && ack[d] && ncap[d] < 24) begin
          cap[d][ncap[d]] = dat[d][7:0];
          ncap[d]++;
        end
        if (reset) begin
          plen[d] = 0; pptr[d] = 0;
          fin_done[d] = 1'b0; fin_err[d] = 1'b0;
          cur[d] = '0;
        end else if (!cur[d].busy && start) begin
          ncap[d] = 0;
          build(d, boot_addr);
          cur[d] = plan[d][0];
          pptr[d] = 1;
        end else if (pptr[d] < plen[d]) begin
          cur[d] = plan[d][pptr[d]];
          pptr[d]++;
        end else begin
          cur[d] = '{cyc: 1'b0, dat: 32'd0, busy: 1'b0, done: fin_done[d], err: fin_err[d]};
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [23:0] a);
    boot_addr = a;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(inout int n);
    while ((busy[0] || busy[1]) && n < 3000) begin
      tick();
      n++;
    end
    chk("idle_bound", 32'(n < 3000), 32'd1);
  endtask

  task automatic set_lat(input int d, input int l0, input int l1, input int l2);
    for (int i = 0; i < 24; i++) lat_tab[d][i] = (i % 3 == 0) ? l0 : ((i % 3 == 1) ? l1 : l2);
  endtask

  task automatic check_caps(input int d, input logic [23:0] a);
    chk($sformatf("dut%0d_ncap", d), 32'(ncap[d]), 32'd24);
    for (int i = 0; i < ncap[d]; i++)
      chk($sformatf("dut%0d_byte%0d", d, i), 32'(cap[d][i]), 32'(exp_byte(a, i, d == 1)));
  endtask

  initial begin
    int n;
    int k;
    set_lat(0, 2, 2, 2);
    set_lat(1, 2, 2, 2);
    tick(); tick(); tick();
    chk("rst_cyc", 32'(cyc[0]), 32'd0);
    chk("rst_dat", dat[1], 32'd0);
    chk("rst_status", {29'd0, busy[0], done[0], err[0]}, 32'd0);
    reset = 1'b0;
    tick();

    // Nominal boot on both masters.
    do_start(24'h0A5000);
    n = 1;
    chk("busy_cycle1", 32'(busy[0]), 32'd1);
    wait_idle(n);
    chk("done_cycle", 32'(n), 32'd97);
    chk("model_len", 32'(plen[0]), 32'd96);
    chk("nom_done", 32'(done[0]), 32'd1);
    for (int i = 0; i < 24; i++) chk($sformatf("nom_byte%0d", i), 32'(cap[0][i]), 32'(nom[i]));
    chk("swap_b1", 32'(cap[1][1]), 32'h0FF);
    chk("swap_b2", 32'(cap[1][2]), 32'h055);
    chk("swap_b3", 32'(cap[1][3]), 32'h099);
    chk("swap_b6", 32'(cap[1][6]), 32'h00A);
    check_caps(1, 24'h0A5000);

    // Timeout on the short-timeout master, then recovery.
    set_lat(1, NEVER, NEVER, NEVER);
    do_start(24'h123456);
    n = 1; k = 0;
    while (stb[1] && k < 50) begin
      k++; tick(); n++;
    end
    chk("tmo_stb_cycles", 32'(k), 32'd10);
    chk("tmo_err", 32'(err[1]), 32'd1);
    chk("tmo_done", 32'(done[1]), 32'd0);
    chk("tmo_busy", 32'(busy[1]), 32'd0);
    wait_idle(n);
    set_lat(1, 2, 2, 2);
    do_start(24'hFFFFFF);
    n = 1;
    wait_idle(n);
    chk("recover_err", 32'(err[1]), 32'd0);
    chk("recover_done", 32'(done[1]), 32'd1);
    check_caps(1, 24'hFFFFFF);

    // Start while busy must not disturb the latched address.
    do_start(24'h5A1234);
    n = 1;
    while (ncap[0] < 5 && n < 200) begin
      tick(); n++;
    end
    boot_addr = 24'hC30F0F;
    start = 1'b1;
    tick(); n++;
    start = 1'b0;
    wait_idle(n);
    chk("busy_start_cycles", 32'(n), 32'd97);
    chk("busy_start_b7", 32'(cap[0][7]), 32'h034);
    chk("busy_start_b11", 32'(cap[0][11]), 32'h05A);
    check_caps(0, 24'h5A1234);

    // Reset in the middle of byte 9.
    do_start(24'h0A5000);
    n = 1;
    while (!(ncap[0] == 9 && stb[0]) && n < 200) begin
      tick(); n++;
    end
    chk("reached_byte9", 32'(n < 200), 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_cyc", 32'(cyc[0]), 32'd0);
    chk("mid_rst_stb", 32'(stb[1]), 32'd0);
    chk("mid_rst_status", {26'd0, busy[0], done[0], err[0], busy[1], done[1], err[1]}, 32'd0);
    reset = 1'b0;
    tick();
    do_start(24'h0A5000);
    n = 1;
    wait_idle(n);
    chk("restart_first", 32'(cap[0][0]), 32'h0FF);
    check_caps(0, 24'h0A5000);

    // Variable-latency responder: 1, 5 and TIMEOUT-1 cycles of waiting.
    set_lat(0, 1, 5, T1 - 1);
    set_lat(1, 1, 5, T1 - 1);
    do_start(24'h0A5000);
    n = 1;
    wait_idle(n);
    chk("var_cycles", 32'(n), 32'd169);
    chk("var_plan_len", 32'(plen[1]), 32'd168);
    chk("var_err", 32'(err[1]), 32'd0);
    chk("var_done", 32'(done[1]), 32'd1);
    check_caps(1, 24'h0A5000);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icap_reboot_master.md
Name: icap_reboot_master

Overview:
- Wishbone initiator that drives the 8-bit ICAP Wishbone responder.
- On a start pulse it issues the fixed Spartan-3A multiboot (IPROG) command sequence, one byte per Wishbone write, which reboots the FPGA from a selectable SPI flash address.
- Sits beside the ICAP responder on the control-lib Wishbone fabric, is triggered by a settings-bus strobe, and reports busy/done/error status back.

Parameters:
- SPI_OPCODE, 8'h0B, SPI read opcode placed in GENERAL2[15:8].
- BIT_SWAP, 1, when 1 each byte is bit-reversed (bit0<->bit7) before driving dat_o, as ICAP_SPARTAN3A requires.
- TIMEOUT, 255, maximum cycles to wait for ack_i per transfer; range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  single-cycle trigger; ignored while busy.
- boot_addr  in  24  flash start address; latched on an accepted start.
- cyc_o  out  1  Wishbone cycle.
- stb_o  out  1  Wishbone strobe.
- we_o  out  1  Wishbone write enable.
- dat_o  out  32  {24'd0, cmd_byte}.
- ack_i  in  1  Wishbone acknowledge from the ICAP responder.
- busy  out  1  sequence in progress.
- done  out  1  sticky: full sequence acknowledged.
- err  out  1  sticky: ack timeout occurred.

Behaviour:
- Clock and reset: clock clk; reset is synchronous, active-high, named reset.
- Reset values:
  - cyc_o=stb_o=we_o=0, dat_o=0, busy=0, done=0, err=0.
  - State IDLE, byte index 0, timeout counter 0, latched address 0.
- Sequence (12 words of 16 bits, 24 bytes, each word MSB byte first):
  - FFFF, AA99, 3261, A[15:0], 3281, {SPI_OPCODE, A[23:16]}, 30A1, 000E, 2000, 2000, 2000, 2000.
  - A is the latched boot_addr.
  - Byte index i (0..23) selects word i>>1; i[0]=0 selects the high byte.
- States: IDLE, ISSUE, GAP, DONE, ERR.
- IDLE:
  - Outputs quiet.
  - start=1 -> latch boot_addr, clear done/err, index=0, timeout counter=0, go ISSUE.
- ISSUE:
  - cyc_o=stb_o=we_o=1; dat_o holds the current byte and is stable for the whole transfer.
  - Each cycle without ack_i increments the timeout counter.
  - ack_i=1: deassert cyc/stb/we at this same edge and go GAP.
  - Counter reaches TIMEOUT with no ack: deassert cyc/stb/we and go ERR.
  - An ack arriving on the same cycle as the timeout wins (treated as ack).
- GAP:
  - One cycle with cyc_o=stb_o=0; guarantees the responder returns to its idle state.
  - If index==23 go DONE; else index+1, timeout counter=0, go ISSUE.
- DONE: done=1, busy=0. Behaves as IDLE: start restarts the sequence and clears done.
- ERR: err=1, busy=0. Behaves as IDLE: start restarts from index 0 and clears err.
- busy=1 exactly while in ISSUE or GAP.
- start asserted while busy is ignored; the latched address does not change.
- ack_i while not in ISSUE is ignored.
- Reset mid-sequence: cyc_o/stb_o drop on that edge and the index returns to 0; no partial byte is retried.
- Timing against the ICAP responder (ack 2 cycles after stb):
  - 3 ISSUE cycles + 1 GAP cycle per byte.
  - start to done = 1 + 24*4 = 97 cycles.
- dat_o returns to 0 outside ISSUE.

Decomposition:
- Shared package icap_pkg holds:
  - ICAP_DUMMY=16'hFFFF, ICAP_SYNC=16'hAA99.
  - ICAP_WR_GEN1=16'h3261, ICAP_WR_GEN2=16'h3281, ICAP_WR_CMD=16'h30A1.
  - ICAP_CMD_REBOOT=16'h000E, ICAP_NOOP=16'h2000.
  - ICAP_SEQ_WORDS=12, state encodings.
- One combinational sub-module, icap_reboot_rom:
  - Inputs: word index, latched address, SPI_OPCODE.
  - Output: 16-bit word.
- Byte select and BIT_SWAP stay in the master.

Test Plan:
- Nominal boot: model responder (ack 2 cycles after stb), boot_addr=24'h0A_5000, BIT_SWAP=0 -> 24 writes in order:
  - FF FF AA 99 32 61 50 00 32 81 0B 0A 30 A1 00 0E 20 00 20 00 20 00 20 00.
  - done=1 at cycle 97 after start; busy high cycles 1..96.
- BIT_SWAP=1, same run -> second byte captured is 8'hFF, third is 8'h55 (AA reversed), fourth is 8'h99, seventh is 8'h0A (50 reversed).
- Timeout: responder never acks, TIMEOUT=10 -> stb_o drops after 10 cycles on byte 0, err=1, done=0, busy=0. A later start with a working responder clears err and completes.
- start pulses during busy (byte 5) with a different boot_addr -> ignored; captured bytes still match the first address.
- Reset asserted mid-byte 9 -> cyc_o/stb_o=0 on the next edge, all status 0. Fresh start resends from byte FF at index 0.
- Variable-latency responder (ack after 1, 5, then TIMEOUT-1 cycles) -> no err, each byte held stable until ack, one GAP cycle observed between every pair of transfers.
